// File: rtl/tour_cmd.sv
// Replays the solved knight's tour as two motion commands per move (vertical, then horizontal)
// and muxes them with host UART commands onto the single cmd/cmd_rdy path.
// Latency: start_tour or send_resp to next leg cmd_rdy is 1 clk; cmd_rdy is a Moore output held until clr_cmd_rdy.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_FANFARE = 4'b0011;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;
  localparam logic [7:0] HDG_WEST  = 8'h3F;

  localparam logic [7:0] RESP_MORE = 8'h5A;
  localparam logic [7:0] RESP_DONE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VERT  = 3'd1,
    HOLDV = 3'd2,
    HORZ  = 3'd3,
    HOLDH = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;

  logic       dx_pos, dy_pos;
  logic [3:0] dx_mag, dy_mag;
  logic [15:0] vert_cmd, horz_cmd;
  logic       last_move;

  assign mv_indx   = mv_indx_q;
  assign last_move = (mv_indx_q == LAST_IDX);

  // Decode the move into signed leg lengths; the lowest set bit wins, an empty move gives zero-length legs.
  always_comb begin
    dx_pos = 1'b0;
    dx_mag = 4'd0;
    dy_pos = 1'b0;
    dy_mag = 4'd0;
    if (move[0]) begin
      dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2;
    end else if (move[1]) begin
      dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2;
    end else if (move[2]) begin
      dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1;
    end else if (move[3]) begin
      dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1;
    end else if (move[4]) begin
      dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2;
    end else if (move[5]) begin
      dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2;
    end else if (move[6]) begin
      dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1;
    end else if (move[7]) begin
      dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1;
    end
  end

  assign vert_cmd = {OP_MOVE,    dy_pos ? HDG_NORTH : HDG_SOUTH, dy_mag};
  assign horz_cmd = {OP_FANFARE, dx_pos ? HDG_EAST  : HDG_WEST,  dx_mag};

  // State and move index registers; reset drops any tour in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Next state and Moore outputs; the UART path is only visible while idle.
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    cmd       = cmd_UART;
    cmd_rdy   = 1'b0;
    resp      = RESP_MORE;
    unique case (state_q)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_DONE;
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = 5'd0;
        end
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLDV;
      end
      HOLDV: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLDH;
      end
      HOLDH: begin
        cmd  = horz_cmd;
        // The final leg's ack tells the host the tour is complete.
        resp = last_move ? RESP_DONE : RESP_MORE;
        if (send_resp) begin
          if (last_move) begin
            state_d = IDLE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
module tb_tour_cmd;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int n_vec;
  int n_err;

  // TourLogic model: 5x5 tour starting at the centre square
  logic [7:0]  tour_mv  [0:31];
  logic [31:0] tour_exp [0:23];   // {vertical cmd, horizontal cmd}, hand computed
  logic [7:0]  move_ovr;
  logic        use_tour;

  assign move = use_tour ? tour_mv[mv_indx] : move_ovr;

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // all stimulus changes and checks happen 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    cmd_rdy_UART = 1'b0;
    cmd_UART     = 16'h0000;
    #2;
    n_vec++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    n_vec++;
    if (mv_indx !== 5'd0) begin n_err++; $display("FAIL reset_mv_indx: got %0d want 0", mv_indx); end
    n_vec++;
    if (resp !== 8'hA5) begin n_err++; $display("FAIL reset_resp: got %h want a5", resp); end
    cmd_rdy_UART = 1'b1;
    cmd_UART     = 16'h2003;
    #1;
    n_vec++;
    if (cmd !== 16'h2003 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL reset_uart_path: got cmd=%h rdy=%b want 2003/1", cmd, cmd_rdy);
    end
    rst_n = 1'b1;
    tick();
    cmd_rdy_UART = 1'b0;
    tick();
  endtask

  task automatic test_single_move();
    use_tour = 1'b0;
    move_ovr = 8'h01;
    pulse_start();
    n_vec++;
    if (cmd !== 16'h2002 || cmd_rdy !== 1'b1 || resp !== 8'h5A) begin
      n_err++; $display("FAIL single_vert: got cmd=%h rdy=%b resp=%h want 2002/1/5a", cmd, cmd_rdy, resp);
    end
    pulse_clr();
    n_vec++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL single_holdv: got rdy=%b want 0", cmd_rdy); end
    pulse_send();
    n_vec++;
    if (cmd !== 16'h3BF1 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL single_horz: got cmd=%h rdy=%b want 3bf1/1", cmd, cmd_rdy);
    end
    pulse_clr();
    pulse_send();
    n_vec++;
    if (mv_indx !== 5'd1 || resp !== 8'h5A || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL single_next: got idx=%0d resp=%h rdy=%b want 1/5a/1", mv_indx, resp, cmd_rdy);
    end
    do_reset();
  endtask

  task automatic test_decode();
    use_tour = 1'b0;
    move_ovr = 8'h08;
    pulse_start();
    n_vec++;
    if (cmd !== 16'h27F1) begin n_err++; $display("FAIL dec_b3_vert: got %h want 27f1", cmd); end
    pulse_clr();
    pulse_send();
    n_vec++;
    if (cmd !== 16'h33F2) begin n_err++; $display("FAIL dec_b3_horz: got %h want 33f2", cmd); end
    pulse_clr();
    // not one-hot: bit 2 beats bit 3
    move_ovr = 8'h0C;
    pulse_send();
    n_vec++;
    if (cmd !== 16'h2001) begin n_err++; $display("FAIL dec_multi_vert: got %h want 2001", cmd); end
    pulse_clr();
    pulse_send();
    n_vec++;
    if (cmd !== 16'h33F2) begin n_err++; $display("FAIL dec_multi_horz: got %h want 33f2", cmd); end
    pulse_clr();
    move_ovr = 8'h00;
    pulse_send();
    n_vec++;
    if (cmd !== 16'h27F0 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL dec_zero_vert: got %h rdy=%b want 27f0/1", cmd, cmd_rdy);
    end
    pulse_clr();
    pulse_send();
    n_vec++;
    if (cmd !== 16'h33F0 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL dec_zero_horz: got %h rdy=%b want 33f0/1", cmd, cmd_rdy);
    end
    do_reset();
  endtask

  task automatic test_full_tour();
    int ncmd;
    ncmd = 0;
    use_tour = 1'b1;
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      n_vec++;
      if (cmd_rdy !== 1'b1 || mv_indx !== 5'(k) || cmd !== tour_exp[k][31:16]) begin
        n_err++;
        $display("FAIL tour_vert[%0d]: got rdy=%b idx=%0d cmd=%h want 1/%0d/%h",
                 k, cmd_rdy, mv_indx, cmd, k, tour_exp[k][31:16]);
      end
      if (cmd_rdy === 1'b1) ncmd++;
      pulse_clr();
      pulse_send();
      n_vec++;
      if (cmd_rdy !== 1'b1 || mv_indx !== 5'(k) || cmd !== tour_exp[k][15:0]) begin
        n_err++;
        $display("FAIL tour_horz[%0d]: got rdy=%b idx=%0d cmd=%h want 1/%0d/%h",
                 k, cmd_rdy, mv_indx, cmd, k, tour_exp[k][15:0]);
      end
      if (cmd_rdy === 1'b1) ncmd++;
      pulse_clr();
      n_vec++;
      if (k == 23) begin
        if (resp !== 8'hA5) begin n_err++; $display("FAIL tour_last_resp: got %h want a5", resp); end
      end else begin
        if (resp !== 8'h5A) begin n_err++; $display("FAIL tour_resp[%0d]: got %h want 5a", k, resp); end
      end
      pulse_send();
    end
    cmd_UART = 16'hBEEF;
    #1;
    n_vec++;
    if (ncmd != 48) begin n_err++; $display("FAIL tour_cmd_count: got %0d want 48", ncmd); end
    n_vec++;
    if (cmd !== 16'hBEEF || cmd_rdy !== 1'b0 || resp !== 8'hA5 || mv_indx !== 5'd23) begin
      n_err++;
      $display("FAIL tour_end_idle: got cmd=%h rdy=%b resp=%h idx=%0d want beef/0/a5/23",
               cmd, cmd_rdy, resp, mv_indx);
    end
    tick();
  endtask

  task automatic test_contention();
    use_tour = 1'b1;
    // start_tour alongside a UART command: UART command shown this cycle
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b1;
    start_tour   = 1'b1;
    #1;
    n_vec++;
    if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL start_with_uart: got cmd=%h rdy=%b want 1234/1", cmd, cmd_rdy);
    end
    tick();
    start_tour   = 1'b0;
    cmd_UART     = 16'hFFFF;
    n_vec++;
    if (cmd !== 16'h27F1 || cmd_rdy !== 1'b1 || mv_indx !== 5'd0) begin
      n_err++; $display("FAIL uart_ignored_vert: got cmd=%h rdy=%b idx=%0d want 27f1/1/0", cmd, cmd_rdy, mv_indx);
    end
    // clr and send together in VERT: only the clear is taken
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    n_vec++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL clr_send_vert: got rdy=%b want 0", cmd_rdy); end
    tick();
    n_vec++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL uart_no_extra_cmd: got rdy=%b want 0", cmd_rdy); end
    cmd_rdy_UART = 1'b0;
    pulse_send();
    n_vec++;
    if (cmd !== 16'h33F2 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL contention_horz: got cmd=%h rdy=%b want 33f2/1", cmd, cmd_rdy);
    end
    // send_resp alone in HORZ, and start_tour mid-tour, are ignored
    pulse_send();
    pulse_start();
    n_vec++;
    if (cmd !== 16'h33F2 || cmd_rdy !== 1'b1 || mv_indx !== 5'd0) begin
      n_err++; $display("FAIL send_in_horz: got cmd=%h rdy=%b idx=%0d want 33f2/1/0", cmd, cmd_rdy, mv_indx);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_tour();
    use_tour = 1'b1;
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      pulse_clr();
      pulse_send();
      pulse_clr();
      pulse_send();
    end
    pulse_clr();
    pulse_send();
    n_vec++;
    if (mv_indx !== 5'd7 || cmd !== 16'h3BF2 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_horz7: got idx=%0d cmd=%h rdy=%b want 7/3bf2/1", mv_indx, cmd, cmd_rdy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0 || resp !== 8'hA5) begin
      n_err++; $display("FAIL async_reset: got rdy=%b idx=%0d resp=%h want 0/0/a5", cmd_rdy, mv_indx, resp);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0) begin
      n_err++; $display("FAIL no_resume: got rdy=%b idx=%0d want 0/0", cmd_rdy, mv_indx);
    end
    pulse_start();
    n_vec++;
    if (mv_indx !== 5'd0 || cmd !== 16'h27F1 || cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL restart: got idx=%0d cmd=%h rdy=%b want 0/27f1/1", mv_indx, cmd, cmd_rdy);
    end
    do_reset();
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    start_tour   = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    move_ovr     = 8'h00;
    use_tour     = 1'b0;
    for (int i = 0; i < 32; i++) tour_mv[i] = 8'h00;
    tour_mv[0]  = 8'h08; tour_mv[1]  = 8'h01; tour_mv[2]  = 8'h80; tour_mv[3]  = 8'h20;
    tour_mv[4]  = 8'h10; tour_mv[5]  = 8'h04; tour_mv[6]  = 8'h02; tour_mv[7]  = 8'h80;
    tour_mv[8]  = 8'h40; tour_mv[9]  = 8'h10; tour_mv[10] = 8'h08; tour_mv[11] = 8'h02;
    tour_mv[12] = 8'h01; tour_mv[13] = 8'h40; tour_mv[14] = 8'h20; tour_mv[15] = 8'h08;
    tour_mv[16] = 8'h02; tour_mv[17] = 8'h02; tour_mv[18] = 8'h40; tour_mv[19] = 8'h80;
    tour_mv[20] = 8'h10; tour_mv[21] = 8'h20; tour_mv[22] = 8'h04; tour_mv[23] = 8'h08;
    tour_exp[0]  = 32'h27F1_33F2; tour_exp[1]  = 32'h2002_3BF1; tour_exp[2]  = 32'h2001_3BF2;
    tour_exp[3]  = 32'h27F2_3BF1; tour_exp[4]  = 32'h27F2_33F1; tour_exp[5]  = 32'h2001_33F2;
    tour_exp[6]  = 32'h2002_33F1; tour_exp[7]  = 32'h2001_3BF2; tour_exp[8]  = 32'h27F1_3BF2;
    tour_exp[9]  = 32'h27F2_33F1; tour_exp[10] = 32'h27F1_33F2; tour_exp[11] = 32'h2002_33F1;
    tour_exp[12] = 32'h2002_3BF1; tour_exp[13] = 32'h27F1_3BF2; tour_exp[14] = 32'h27F2_3BF1;
    tour_exp[15] = 32'h27F1_33F2; tour_exp[16] = 32'h2002_33F1; tour_exp[17] = 32'h2002_33F1;
    tour_exp[18] = 32'h27F1_3BF2; tour_exp[19] = 32'h2001_3BF2; tour_exp[20] = 32'h27F2_33F1;
    tour_exp[21] = 32'h27F2_3BF1; tour_exp[22] = 32'h2001_33F2; tour_exp[23] = 32'h27F1_33F2;

    test_reset();
    test_single_move();
    test_decode();
    test_full_tour();
    test_contention();
    test_reset_mid_tour();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
